// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data-memory port between
// num_req_p core requesters. Exactly one transaction is in flight at a time:
// a request is accepted in IDLE, issued to memory, its response captured,
// and then handed back to the requester that was granted.
module dmem_arbiter #(
  parameter int num_req_p  = 2,
  parameter int id_width_p = 1,
  parameter int timeout_p  = 255
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [num_req_p-1:0]      req_valid_i,
  input  logic [num_req_p-1:0]      req_wen_i,
  input  logic [num_req_p-1:0]      req_byte_i,
  input  logic [32*num_req_p-1:0]   req_addr_i,
  input  logic [32*num_req_p-1:0]   req_wdata_i,
  output logic [num_req_p-1:0]      req_yumi_o,

  output logic [num_req_p-1:0]      resp_valid_o,
  output logic [31:0]               resp_data_o,
  input  logic [num_req_p-1:0]      resp_yumi_i,

  output logic                      mem_valid_o,
  output logic                      mem_wen_o,
  output logic                      mem_byte_o,
  output logic [31:0]               mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  input  logic                      mem_yumi_i,

  input  logic                      mem_resp_valid_i,
  input  logic [31:0]               mem_resp_data_i,
  output logic                      mem_resp_yumi_o,

  output logic [id_width_p-1:0]     grant_id_o,
  output logic                      busy_o,
  output logic                      error_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_DELIVER   = 2'd3
  } state_e;

  // The timeout counter is 16 bits wide, enough for any legal timeout_p.
  localparam logic [15:0]           TMO_LIMIT = 16'(timeout_p);
  localparam logic [id_width_p-1:0] LAST_ID   = id_width_p'(num_req_p - 1);

  state_e                  state;
  logic [id_width_p-1:0]   rr_ptr;
  logic [id_width_p-1:0]   grant_id;
  logic [id_width_p-1:0]   grant_nxt;
  logic                    any_req;
  logic [15:0]             tmo_cnt;
  logic                    error_q;

  // Latched copy of the accepted request and of the memory response.
  logic                    wen_q;
  logic                    byte_q;
  logic [31:0]             addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;

  // Fields of the requester that would be granted this cycle.
  logic                    sel_wen;
  logic                    sel_byte;
  logic [31:0]             sel_addr;
  logic [31:0]             sel_wdata;

  logic                    deliver_done;
  logic [id_width_p-1:0]   rr_nxt;

  // Circular priority search starting at rr_ptr; scanning offsets from the
  // far end down lets the closest valid requester overwrite later ones.
  always_comb begin
    int idx;
    idx       = 0;
    any_req   = 1'b0;
    grant_nxt = '0;
    for (int off = num_req_p - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % num_req_p;
      if (req_valid_i[idx]) begin
        any_req   = 1'b1;
        grant_nxt = id_width_p'(idx);
      end
    end
  end

  // Route the candidate requester's fields to the capture registers.
  always_comb begin
    sel_wen   = req_wen_i[grant_nxt];
    sel_byte  = req_byte_i[grant_nxt];
    sel_addr  = req_addr_i[int'(grant_nxt)*32 +: 32];
    sel_wdata = req_wdata_i[int'(grant_nxt)*32 +: 32];
  end

  // Accept strobe is only offered while idle, and never while reset is
  // being applied, since the grant would not be captured in that cycle.
  always_comb begin
    req_yumi_o = '0;
    if ((state == S_IDLE) && any_req && !reset) begin
      req_yumi_o[grant_nxt] = 1'b1;
    end
  end

  // Response is presented only to the requester that owns the transaction.
  always_comb begin
    resp_valid_o = '0;
    if (state == S_DELIVER) begin
      resp_valid_o[grant_id] = 1'b1;
    end
  end

  // The requester's consume bit retires the transaction; the next search
  // starts one past the requester just served.
  always_comb begin
    deliver_done = (state == S_DELIVER) && resp_yumi_i[grant_id];
    rr_nxt       = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  end

  // Main transaction FSM plus timeout supervision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      error_q  <= 1'b0;
      tmo_cnt  <= '0;
      wen_q    <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            wen_q    <= sel_wen;
            byte_q   <= sel_byte;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            grant_id <= grant_nxt;
            tmo_cnt  <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_yumi_i) begin
            state <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (mem_resp_valid_i) begin
            rdata_q <= mem_resp_data_i;
            state   <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (deliver_done) begin
            rr_ptr <= rr_nxt;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A slow memory only raises the sticky flag; the transaction itself
      // keeps waiting and completes normally if the memory ever answers.
      if ((state == S_ISSUE) || (state == S_WAIT_RESP)) begin
        if (tmo_cnt != TMO_LIMIT) begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if ((tmo_cnt + 16'd1) == TMO_LIMIT) begin
            error_q <= 1'b1;
          end
        end
      end
    end
  end

  // Memory-side request is a straight view of the latched fields, so it is
  // stable for as long as the memory withholds mem_yumi_i.
  always_comb begin
    mem_valid_o     = (state == S_ISSUE);
    mem_wen_o       = wen_q;
    mem_byte_o      = byte_q;
    mem_addr_o      = addr_q;
    mem_wdata_o     = wdata_q;
    mem_resp_yumi_o = (state == S_WAIT_RESP) && mem_resp_valid_i && !reset;
    resp_data_o     = rdata_q;
    grant_id_o      = grant_id;
    busy_o          = (state != S_IDLE);
    error_o         = error_q;
  end

endmodule
